// File: rtl/md_sched_unit.sv
// md_sched_unit: multicycle mult/div scheduler owning HI/LO, with D-stage stall generation
module md_sched_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0] op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q, res_hi_d, res_lo_d;
  logic busy_q, wr_d;
  logic [63:0] prod_d;
  always_comb begin
    prod_d = op_q[0] ? {32'b0, a_q} * {32'b0, b_q}
                     : 64'($signed(64'($signed(a_q))) * $signed(64'($signed(b_q))));
    wr_d = !op_q[1] || (b_q != 32'b0);
    res_hi_d = prod_d[63:32];
    res_lo_d = prod_d[31:0];
    if (op_q[1]) begin
      // INT_MIN / -1 overflows the signed quotient; pin the architectural result
      if (!op_q[0] && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
        res_lo_d = 32'h8000_0000;
        res_hi_d = 32'b0;
      end else begin
        res_lo_d = op_q[0] ? a_q / b_q : 32'($signed(a_q) / $signed(b_q));
        res_hi_d = op_q[0] ? a_q % b_q : 32'($signed(a_q) % $signed(b_q));
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          if (op <= 3'd3) begin
            op_q    <= op[1:0];
            a_q     <= rs_val;
            b_q     <= rt_val;
            busy_q  <= 1'b1;
            state_q <= op[1] ? DIV : MUL;
            cnt_q   <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (op == 3'd4) hi_q <= rs_val;
          else if (op == 3'd5) lo_q <= rs_val;
        end
        MUL, DIV: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (wr_d) begin
              hi_q <= res_hi_d;
              lo_q <= res_lo_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy     = busy_q;
  assign md_stall = d_md_use & (busy_q | (start & (op <= 3'd3)));
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
endmodule
